// File: rtl/seq_mul_ctrl_if.sv
// Operand and result handshake bundle between a source/consumer and seq_mul_ctrl.
// The master drives operands and result acceptance; the slave is the controller.
interface seq_mul_ctrl_if #(
  parameter int unsigned WIDTH = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_product
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_product
  );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Feeds operand pairs to a right-shift sequential multiplier, waits out its fixed
// iteration count, then holds the captured product on a valid/ready result port.
module seq_mul_ctrl #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned MUL_CYCLES = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_mul_ctrl_if.slave      host,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               busy,
  output logic [CNT_W-1:0]   done_count
);

  localparam int unsigned CntBits = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StHold
  } state_e;

  state_e               state_q, state_d;
  logic [CntBits-1:0]   cnt_q;
  logic [WIDTH-1:0]     mul_a_q, mul_b_q;
  logic [2*WIDTH-1:0]   out_product_q;
  logic [CNT_W-1:0]     done_count_q;
  logic                 cnt_done;
  logic                 accept;
  logic                 consume;

  // Capture one edge after the multiplier's last update, so the product is settled.
  assign cnt_done = (cnt_q == CntBits'(MUL_CYCLES));
  assign accept   = (state_q == StIdle) && host.in_valid;
  assign consume  = (state_q == StHold) && host.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (host.in_valid) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (cnt_done) state_d = StHold;
      StHold:  if (host.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_product_q <= '0;
      done_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mul_a_q <= host.in_a;
        mul_b_q <= host.in_b;
      end
      if (state_q == StLoad) begin
        cnt_q <= '0;
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + CntBits'(1);
      end
      if ((state_q == StRun) && cnt_done) begin
        out_product_q <= mul_product;
      end
      if (consume) begin
        done_count_q <= done_count_q + CNT_W'(1);
      end
    end
  end

  assign host.in_ready    = (state_q == StIdle);
  assign host.out_valid   = (state_q == StHold);
  assign host.out_product = out_product_q;
  assign mul_load         = (state_q == StLoad);
  assign mul_a            = mul_a_q;
  assign mul_b            = mul_b_q;
  assign busy             = (state_q != StIdle);
  assign done_count       = done_count_q;

endmodule
